// File: rtl/md_unit.sv
// md_unit: iterative unsigned multiply/divide unit for the execute stage.
//
// One product (MUL/MULHU) or quotient/remainder (DIVU/REMU) per request.
// Each request occupies WIDTH+2 cycles: the IDLE launch cycle, WIDTH RUN
// iterations and one DONE cycle.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset, returns the unit to IDLE
//   start   request, held high while the M-type instruction sits in EX
//   op      00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   a, b    operand A / dividend, operand B / divisor
//   result  registered result, valid with done, held until the next launch
//   busy    high while iterating (RUN)
//   done    one-cycle pulse in DONE
//   stall   combinational freeze for the upstream pipeline (enable = ~stall)
//
// State table:
//   IDLE | waiting for start; latches operands on launch
//   RUN  | one shift-add / restoring-divide iteration per cycle
//   DONE | result valid, pipeline advances; start is ignored here

module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] result_q;

    logic             launch;
    logic             last;

    // Multiply iteration: the multiplier lives in prod_lo and is consumed
    // LSB-first while the product grows into the upper half.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] prod_hi_nxt;
    logic [WIDTH-1:0] prod_lo_nxt;

    // Divide iteration: the dividend lives in quot and is consumed MSB-first
    // while quotient bits are shifted in at the bottom.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quot_nxt;

    logic [WIDTH-1:0] sel_result;

    assign launch = (state == IDLE) && start;
    assign last   = (cnt == CNT_LAST);

    always_comb begin
        mul_sum     = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, mcand} : '0);
        prod_hi_nxt = mul_sum[WIDTH:1];
        prod_lo_nxt = {mul_sum[0], prod_lo[WIDTH-1:1]};
    end

    // The remainder is always below the divisor (or a prefix of the dividend
    // when dividing by zero), so the W-bit modulo difference is exact when
    // the full-width compare says the subtraction is non-negative.
    always_comb begin
        div_shift = {rem, quot[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, divisor};
        div_diff  = div_shift[WIDTH-1:0] - divisor;
        rem_nxt   = div_ge ? div_diff : div_shift[WIDTH-1:0];
        quot_nxt  = {quot[WIDTH-2:0], div_ge};
    end

    always_comb begin
        sel_result = prod_lo_nxt;
        unique case (op_q)
            2'b00:   sel_result = prod_lo_nxt;
            2'b01:   sel_result = prod_hi_nxt;
            2'b10:   sel_result = quot_nxt;
            default: sel_result = rem_nxt;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        stall     = 1'b0;
        unique case (state)
            IDLE: begin
                stall = start;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                stall = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            op_q     <= '0;
            mcand    <= '0;
            prod_hi  <= '0;
            prod_lo  <= '0;
            divisor  <= '0;
            quot     <= '0;
            rem      <= '0;
            result_q <= '0;
        end else if (launch) begin
            cnt     <= '0;
            op_q    <= op;
            mcand   <= a;
            prod_hi <= '0;
            prod_lo <= b;
            divisor <= b;
            quot    <= a;
            rem     <= '0;
        end else if (state == RUN) begin
            prod_hi <= prod_hi_nxt;
            prod_lo <= prod_lo_nxt;
            quot    <= quot_nxt;
            rem     <= rem_nxt;
            if (last) begin
                cnt      <= '0;
                result_q <= sel_result;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        busy;
    logic        done;
    logic        stall;

    int checks = 0;
    int errors = 0;

    md_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Caller positions the bench just after a negedge with the unit in IDLE.
    // Drives the request, follows it to the done pulse and checks latency,
    // stall length, stall during done and the result.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] exp,
                         input bit scramble, input bit keep_start);
        int cyc;
        int stall_cnt;
        int overlap;
        bit got;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        chk({tag, "_launch_busy"},  {31'd0, busy},  32'd0);
        chk({tag, "_launch_stall"}, {31'd0, stall}, 32'd1);
        cyc = 0;
        stall_cnt = 0;
        overlap = 0;
        got = 1'b0;
        while (!got && cyc < 100) begin
            cyc++;
            if (busy && done) overlap++;
            if (done) got = 1'b1;
            else if (stall) stall_cnt++;
            if (!got) begin
                @(negedge clk);
                if (scramble && busy) begin
                    op = 2'($urandom);
                    a  = $urandom;
                    b  = $urandom;
                end
                #1;
            end
        end
        chk({tag, "_done_seen"},  {31'd0, got},   32'd1);
        chk({tag, "_latency"},    cyc,            32'd34);
        chk({tag, "_stall_len"},  stall_cnt,      32'd33);
        chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({tag, "_overlap"},    overlap,        32'd0);
        chk({tag, "_result"},     result,         exp);
        if (!keep_start) start = 1'b0;
    endtask

    initial begin
        int done_cnt;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_busy",   {31'd0, busy},  32'd0);
        chk("rst_done",   {31'd0, done},  32'd0);
        chk("rst_stall0", {31'd0, stall}, 32'd0);
        start = 1'b1;
        #1;
        chk("rst_stall1", {31'd0, stall}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        do_op("mul", 2'b00, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 1'b0, 1'b0);
        @(negedge clk);
        do_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        @(negedge clk);
        do_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        @(negedge clk);
        do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0);
        @(negedge clk);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0);
        @(negedge clk);
        do_op("divu_msb", 2'b10, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 1'b0);
        @(negedge clk);
        do_op("remu_msb", 2'b11, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        do_op("divu_zero", 2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        do_op("remu_zero", 2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0);

        // Operands and op scrambled every RUN cycle; launch-time values rule.
        @(negedge clk);
        do_op("scr_divu", 2'b10, 32'd1000, 32'd10, 32'd100, 1'b1, 1'b0);
        @(negedge clk);
        do_op("scr_mulhu", 2'b01, 32'h8000_0000, 32'd4, 32'd2, 1'b1, 1'b0);

        // Back-to-back with start held through DONE: next launch in IDLE.
        @(negedge clk);
        do_op("b2b_remu", 2'b11, 32'd1000, 32'd7, 32'd6, 1'b0, 1'b1);
        op = 2'b00;
        a  = 32'h0000_1234;
        b  = 32'h0000_0010;
        @(negedge clk);
        #1;
        chk("b2b_idle_busy", {31'd0, busy}, 32'd0);
        chk("b2b_idle_done", {31'd0, done}, 32'd0);
        chk("b2b_hold_result", result, 32'd6);
        do_op("b2b_mul", 2'b00, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, 1'b0);

        // Reset mid-RUN aborts the operation.
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd3;
        repeat (6) @(negedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_result_held", result, 32'h0001_2340);
        reset = 1'b1;
        #1;
        chk("abort_busy",   {31'd0, busy},  32'd0);
        chk("abort_done",   {31'd0, done},  32'd0);
        chk("abort_result", result,         32'd0);
        chk("abort_stall",  {31'd0, stall}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        chk("abort_no_done", done_cnt, 32'd0);
        chk("abort_result_after", result, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
